// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings, frame constants
// and the running checksum helper.
package imem_uart_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } ldr_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         LEN_W             = 16;
    localparam logic [1:0] LAST_BYTE_IDX     = 2'd3;

    // Frame checksum is a plain modulo-256 byte sum over the payload.
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port plus loader status, as seen by the loader (master)
// and by the memory/debug side (slave).
interface imem_uart_loader_if #(parameter int ADDR_W = 8);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output imem_we, imem_waddr, imem_wdata, cpu_hold, done, error, words_loaded
    );

    modport slave (
        input imem_we, imem_waddr, imem_wdata, cpu_hold, done, error, words_loaded
    );
endinterface

// File: rtl/imem_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, centre sampling, glitch-rejecting start
// check and a one-cycle rx_valid / framing_err pulse at the stop-bit centre.
module uart_rx_byte
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       framing_err
);
    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic             sync1_r, sync2_r, prev_r;
    rx_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             valid_r, valid_s;
    logic [7:0]       byte_r, byte_s;
    logic             ferr_r, ferr_s;

    // Synchroniser, edge history and all receiver state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            prev_r    <= 1'b1;
            state_r   <= RX_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            valid_r   <= 1'b0;
            byte_r    <= 8'h00;
            ferr_r    <= 1'b0;
        end else begin
            sync1_r   <= rxd;
            sync2_r   <= sync1_r;
            prev_r    <= sync2_r;
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            valid_r   <= valid_s;
            byte_r    <= byte_s;
            ferr_r    <= ferr_s;
        end
    end

    // Bit timing and next-state decode; the counter is reset at every sample point.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r + CNT_ONE;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        valid_s   = 1'b0;
        byte_s    = byte_r;
        ferr_s    = 1'b0;
        case (state_r)
            RX_IDLE: begin
                cnt_s = '0;
                if (prev_r && !sync2_r) begin
                    state_s = RX_START;
                end else begin
                    state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_s     = '0;
                    bit_idx_s = 3'd0;
                    if (!sync2_r) begin
                        state_s = RX_DATA;
                    end else begin
                        state_s = RX_IDLE;
                    end
                end else begin
                    state_s = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s   = '0;
                    shift_s = {sync2_r, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_s = RX_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_s = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s   = '0;
                    state_s = RX_IDLE;
                    if (sync2_r) begin
                        valid_s = 1'b1;
                        byte_s  = shift_r;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end else begin
                    state_s = RX_STOP;
                end
            end
            default: begin
                state_s = RX_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    assign rx_valid    = valid_r;
    assign rx_byte     = byte_r;
    assign framing_err = ferr_r;

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: parses SYNC/LEN/payload/CHK frames from UART, writes little-endian
// words into instruction memory and holds the core in reset until a frame verifies.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         ADDR_W       = 8,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rxd,
    imem_uart_loader_if.master  ldr
);
    localparam logic [LEN_W:0]  MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] WORD_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam int              IDX_PAD   = LEN_W - ADDR_W - 1;

    logic       rx_valid_s;
    logic [7:0] rx_byte_s;
    logic       framing_err_s;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rx_valid    (rx_valid_s),
        .rx_byte     (rx_byte_s),
        .framing_err (framing_err_s)
    );

    ldr_state_e        state_r, state_s;
    logic [LEN_W-1:0]  len_r, len_s, n_s, widx_inc_s;
    logic [1:0]        byte_idx_r, byte_idx_s;
    logic [31:0]       word_buf_r, word_buf_s;
    logic [7:0]        sum_r, sum_s;
    logic [ADDR_W:0]   word_idx_r, word_idx_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] waddr_r, waddr_s;
    logic [31:0]       wdata_r, wdata_s;
    logic              hold_r, hold_s;
    logic              done_r, done_s;
    logic              error_r, error_s;
    logic [ADDR_W:0]   loaded_r, loaded_s;

    // Loader state and every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            len_r      <= '0;
            byte_idx_r <= 2'd0;
            word_buf_r <= 32'h0000_0000;
            sum_r      <= 8'h00;
            word_idx_r <= '0;
            we_r       <= 1'b0;
            waddr_r    <= '0;
            wdata_r    <= 32'h0000_0000;
            hold_r     <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            loaded_r   <= '0;
        end else begin
            state_r    <= state_s;
            len_r      <= len_s;
            byte_idx_r <= byte_idx_s;
            word_buf_r <= word_buf_s;
            sum_r      <= sum_s;
            word_idx_r <= word_idx_s;
            we_r       <= we_s;
            waddr_r    <= waddr_s;
            wdata_r    <= wdata_s;
            hold_r     <= hold_s;
            done_r     <= done_s;
            error_r    <= error_s;
            loaded_r   <= loaded_s;
        end
    end

    // Frame parser; a sync byte in IDLE/DONE/ERR starts a fresh frame and re-holds the core.
    always_comb begin
        state_s    = state_r;
        len_s      = len_r;
        byte_idx_s = byte_idx_r;
        word_buf_s = word_buf_r;
        sum_s      = sum_r;
        word_idx_s = word_idx_r;
        we_s       = 1'b0;
        waddr_s    = waddr_r;
        wdata_s    = wdata_r;
        hold_s     = hold_r;
        done_s     = done_r;
        error_s    = error_r;
        loaded_s   = loaded_r;
        n_s        = {rx_byte_s, len_r[7:0]};
        widx_inc_s = {{IDX_PAD{1'b0}}, word_idx_r} + 16'd1;
        if (framing_err_s) begin
            if (state_r inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK}) begin
                state_s = S_ERR;
                error_s = 1'b1;
                done_s  = 1'b0;
                hold_s  = 1'b1;
            end else begin
                state_s = state_r;
            end
        end else if (rx_valid_s) begin
            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (rx_byte_s == SYNC_BYTE) begin
                        state_s    = S_LEN_LO;
                        hold_s     = 1'b1;
                        done_s     = 1'b0;
                        error_s    = 1'b0;
                        loaded_s   = '0;
                        byte_idx_s = 2'd0;
                        sum_s      = 8'h00;
                        word_idx_s = '0;
                    end else begin
                        state_s = state_r;
                    end
                end
                S_LEN_LO: begin
                    len_s[7:0] = rx_byte_s;
                    state_s    = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_s = n_s;
                    if ({1'b0, n_s} > MAX_WORDS) begin
                        state_s = S_ERR;
                        error_s = 1'b1;
                        hold_s  = 1'b1;
                    end else if (n_s == 16'd0) begin
                        state_s = S_CHK;
                    end else begin
                        state_s = S_DATA;
                    end
                end
                S_DATA: begin
                    word_buf_s = {rx_byte_s, word_buf_r[31:8]};
                    sum_s      = chk_add(sum_r, rx_byte_s);
                    if (byte_idx_r == LAST_BYTE_IDX) begin
                        byte_idx_s = 2'd0;
                        we_s       = 1'b1;
                        waddr_s    = word_idx_r[ADDR_W-1:0];
                        wdata_s    = {rx_byte_s, word_buf_r[31:8]};
                        loaded_s   = loaded_r + WORD_ONE;
                        word_idx_s = word_idx_r + WORD_ONE;
                        if (widx_inc_s == len_r) begin
                            state_s = S_CHK;
                        end else begin
                            state_s = S_DATA;
                        end
                    end else begin
                        byte_idx_s = byte_idx_r + 2'd1;
                    end
                end
                S_CHK: begin
                    if (rx_byte_s == sum_r) begin
                        state_s = S_DONE;
                        done_s  = 1'b1;
                        hold_s  = 1'b0;
                    end else begin
                        state_s = S_ERR;
                        error_s = 1'b1;
                        hold_s  = 1'b1;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign ldr.imem_we      = we_r;
    assign ldr.imem_waddr   = waddr_r;
    assign ldr.imem_wdata   = wdata_r;
    assign ldr.cpu_hold     = hold_r;
    assign ldr.done         = done_r;
    assign ldr.error        = error_r;
    assign ldr.words_loaded = loaded_r;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomised frame bench for imem_uart_loader with a write scoreboard and
// frame-level outcome model.
module tb_imem_uart_loader;
    localparam int CPB = 16;
    localparam int AW  = 8;

    logic clk = 1'b0;
    logic rst;
    logic rxd;

    always #5 clk = ~clk;

    imem_uart_loader_if #(.ADDR_W(AW)) bus ();

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .ldr (bus)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] pl[$];
    int         vectors     = 0;
    int         miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none",
                         bus.imem_waddr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("imem_waddr", 32'(bus.imem_waddr), 32'(e.addr));
                check("imem_wdata", bus.imem_wdata, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        rxd = stop;
        repeat (CPB) @(posedge clk);
        rxd = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic check_status(input logic e_done, input logic e_err, input int e_words);
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        check("done", 32'(bus.done), 32'(e_done));
        check("error", 32'(bus.error), 32'(e_err));
        check("cpu_hold", 32'(bus.cpu_hold), 32'(!e_done));
        check("words_loaded", 32'(bus.words_loaded), 32'(e_words));
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_imem_waddr", 32'(bus.imem_waddr), 32'd0);
        check("rst_imem_wdata", bus.imem_wdata, 32'd0);
        check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_words_loaded", 32'(bus.words_loaded), 32'd0);
    endtask

    task automatic fill_random(input int n);
        pl.delete();
        for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    // Sends one frame from pl. bad_k: payload byte with stop=0; rst_k: reset before
    // payload byte rst_k; glitch_k: rxd glitch before payload byte glitch_k (-1 = none).
    task automatic send_frame(input int n, input logic [7:0] chk_delta, input int bad_k,
                              input int rst_k, input int glitch_k);
        logic [7:0] sum;
        int         lim;
        logic       e_done;
        logic       e_err;
        int         e_words;
        bit         aborted;
        sum     = 8'h00;
        aborted = 1'b0;
        lim     = 4 * n;
        if (bad_k >= 0) lim = bad_k;
        else if (rst_k >= 0) lim = rst_k;
        if (n <= 256) begin
            for (int w = 0; w < lim / 4; w++) begin
                wr_t e;
                e.addr = 8'(w);
                e.data = {pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]};
                exp_q.push_back(e);
            end
        end
        send_byte(8'hA5, 1'b1);
        send_byte(8'(n), 1'b1);
        send_byte(8'(n >> 8), 1'b1);
        if (n > 256) begin
            e_done  = 1'b0;
            e_err   = 1'b1;
            e_words = 0;
        end else begin
            for (int k = 0; k < 4 * n && !aborted; k++) begin
                if (k == rst_k) begin
                    @(negedge clk);
                    rst = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    check_reset_values();
                    check("rst_pending_writes", 32'(exp_q.size()), 32'd0);
                    rst = 1'b0;
                    aborted = 1'b1;
                end else begin
                    if (k == glitch_k) begin
                        rxd = 1'b0;
                        repeat (6) @(posedge clk);
                        rxd = 1'b1;
                        repeat (2 * CPB) @(posedge clk);
                    end
                    send_byte(pl[k], (k != bad_k));
                    sum = sum + pl[k];
                    if (k == bad_k) aborted = 1'b1;
                end
            end
            if (!aborted) send_byte(sum + chk_delta, 1'b1);
            e_done  = !aborted && (chk_delta == 8'h00);
            e_err   = !e_done;
            e_words = lim / 4;
        end
        if (rst_k < 0) check_status(e_done, e_err, e_words);
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        repeat (4 * CPB) @(posedge clk);

        // Known-good two-word frame, then the same frame with a wrong checksum.
        pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_frame(2, 8'h00, -1, -1, -1);
        send_frame(2, 8'h01, -1, -1, -1);

        // Empty frame, then an over-length header (257 words).
        pl.delete();
        send_frame(0, 8'h00, -1, -1, -1);
        send_frame(257, 8'h00, -1, -1, -1);

        // Stop-bit fault on the second payload byte, then recovery.
        fill_random(3);
        send_frame(3, 8'h00, 1, -1, -1);
        fill_random(3);
        send_frame(3, 8'h00, -1, -1, -1);

        // Noise bytes in idle-equivalent state ahead of a frame with an rxd glitch.
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h12, 1'b1);
        fill_random(2);
        send_frame(2, 8'h00, -1, -1, 5);

        // Reset after six payload bytes, then a full reload.
        fill_random(3);
        send_frame(3, 8'h00, -1, 6, -1);
        send_frame(3, 8'h00, -1, -1, -1);

        for (int f = 0; f < 6; f++) begin
            int n;
            logic [7:0] d;
            n = $urandom_range(1, 6);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            fill_random(n);
            send_frame(n, d, -1, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
